// File: rtl/hsi_mse_acc_pkg.sv
// Shared types and helpers for the hyperspectral MSE accumulator.
//   state_e    : top-level FSM states
//   acc_width  : accumulator width needed for a full vector of worst-case squares
//   sat_resize : clamp a value to out_w bits, saturating to all-ones on overflow
package hsi_mse_acc_pkg;

  typedef enum logic [1:0] {
    Accum,
    Drain,
    Divide,
    Output
  } state_e;

  // Each square needs 2*elem_w bits; summing up to 2**bands_addr of them adds bands_addr bits.
  function automatic int unsigned acc_width(int unsigned elem_w, int unsigned bands_addr);
    return 2 * elem_w + bands_addr;
  endfunction

  function automatic logic [63:0] sat_resize(logic [63:0] val, int unsigned out_w);
    logic [63:0] mask;
    if (out_w >= 64) begin
      return val;
    end
    mask = (64'd1 << out_w) - 64'd1;
    return ((val & ~mask) != 64'd0) ? mask : val;
  endfunction

endpackage

// File: rtl/hsi_mse_acc_if.sv
// Band stream in / MSE result out bundle for hsi_mse_acc.
//   master : the stream source and result consumer (drives band_*, observes mse_out_*)
//   slave  : the accumulator itself
interface hsi_mse_acc_if #(
  parameter int unsigned ELEMENT_WIDTH = 16,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned REF_WIDTH     = 8
);

  logic                     band_valid;
  logic                     band_ready;
  logic [ELEMENT_WIDTH-1:0] pixel_elem;
  logic [ELEMENT_WIDTH-1:0] ref_elem;
  logic                     band_last;
  logic [REF_WIDTH-1:0]     vector_ref;
  logic                     mse_out_valid;
  logic [WORD_WIDTH-1:0]    mse_out_value;
  logic [REF_WIDTH-1:0]     mse_out_ref;
  logic                     mse_out_truncated;

  modport master (
    output band_valid, pixel_elem, ref_elem, band_last, vector_ref,
    input  band_ready, mse_out_valid, mse_out_value, mse_out_ref, mse_out_truncated
  );

  modport slave (
    input  band_valid, pixel_elem, ref_elem, band_last, vector_ref,
    output band_ready, mse_out_valid, mse_out_value, mse_out_ref, mse_out_truncated
  );

endinterface

// File: rtl/hsi_mse_div.sv
// Sequential restoring divider, one quotient bit per cycle.
// The load cycle already performs the first step, so quotient_o is final and done_o
// pulses exactly DividendWidth cycles after the cycle start_i is high.
//   clk, rst     : clock, async active-high reset
//   clear        : synchronous abort
//   start_i      : load dividend_i / divisor_i (divisor must be non-zero)
//   busy_o       : iterations still pending
//   done_o       : one-cycle pulse, quotient_o valid
//   quotient_o   : quotient, held until the next start_i
module hsi_mse_div #(
  parameter int unsigned DividendWidth = 39,
  parameter int unsigned DivisorWidth  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     start_i,
  input  logic [DividendWidth-1:0] dividend_i,
  input  logic [DivisorWidth-1:0]  divisor_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DividendWidth-1:0] quotient_o
);

  localparam int unsigned CntW = $clog2(DividendWidth + 1);

  logic [DividendWidth-1:0] quo_q, quo_d;
  logic [DivisorWidth-1:0]  rem_q, rem_d;
  logic [DivisorWidth-1:0]  div_q, div_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [DividendWidth-1:0] src_quo, step_quo;
  logic [DivisorWidth-1:0]  src_rem, src_div, step_rem;
  logic [DivisorWidth:0]    rem_sh, rem_sub;

  // One restoring step on either the freshly loaded operands or the running state.
  always_comb begin
    src_rem = rem_q;
    src_quo = quo_q;
    src_div = div_q;
    if (start_i) begin
      src_rem = '0;
      src_quo = dividend_i;
      src_div = divisor_i;
    end
    rem_sh  = {src_rem, src_quo[DividendWidth-1]};
    rem_sub = rem_sh - {1'b0, src_div};
    if (rem_sh >= {1'b0, src_div}) begin
      step_rem = rem_sub[DivisorWidth-1:0];
      step_quo = {src_quo[DividendWidth-2:0], 1'b1};
    end else begin
      // rem_sh < divisor here, so its top bit is zero
      step_rem = rem_sh[DivisorWidth-1:0];
      step_quo = {src_quo[DividendWidth-2:0], 1'b0};
    end
  end

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (clear) begin
      quo_d  = '0;
      rem_d  = '0;
      div_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start_i) begin
      quo_d  = step_quo;
      rem_d  = step_rem;
      div_d  = divisor_i;
      cnt_d  = CntW'(DividendWidth - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = step_quo;
      rem_d = step_rem;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/hsi_mse_acc.sv
// Mean squared error between one hyperspectral pixel and one library vector,
// streamed one band per cycle; feeds the MSE min/max comparator.
//   clk, rst : clock, async active-high reset
//   clear    : synchronous abort to idle, discards the vector in flight
//   bus      : band stream (valid/ready, samples, last, vector_ref) and the
//              registered result (one-cycle valid pulse, value, ref, truncated)
// Pipeline: S1 registers |pixel - ref|, S2 folds its square into the accumulator.
// After the last band: one DRAIN cycle, ACC_WIDTH divider cycles, one OUTPUT cycle.
module hsi_mse_acc
  import hsi_mse_acc_pkg::*;
#(
  parameter int unsigned WORD_WIDTH            = 32,
  parameter int unsigned ELEMENT_WIDTH         = 16,
  parameter int unsigned HSI_BANDS             = 128,
  parameter int unsigned HSI_BANDS_ADDR        = $clog2(HSI_BANDS),
  parameter int unsigned HSI_LIBRARY_SIZE      = 256,
  parameter int unsigned HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE),
  parameter int unsigned ACC_WIDTH             = acc_width(ELEMENT_WIDTH, HSI_BANDS_ADDR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  hsi_mse_acc_if.slave  bus
);

  localparam int unsigned CntW = HSI_BANDS_ADDR + 1;

  state_e                           state_q, state_d;
  logic                             ready_q, ready_d;
  logic [ELEMENT_WIDTH-1:0]         s1_diff_q, s1_diff_d;
  logic                             s1_valid_q, s1_valid_d;
  logic [ACC_WIDTH-1:0]             acc_q, acc_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] ref_q, ref_d;
  logic                             trunc_q, trunc_d;
  logic                             out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0]            out_value_q, out_value_d;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] out_ref_q, out_ref_d;
  logic                             out_trunc_q, out_trunc_d;

  logic                       hs;
  logic [ELEMENT_WIDTH-1:0]   abs_diff;
  logic [2*ELEMENT_WIDTH-1:0] sq;
  logic [CntW-1:0]            cnt_inc;
  logic                       div_start;
  logic                       div_busy;
  logic                       div_done;
  logic [ACC_WIDTH-1:0]       div_quo;

  assign hs       = bus.band_valid && ready_q;
  assign abs_diff = (bus.pixel_elem >= bus.ref_elem) ? (bus.pixel_elem - bus.ref_elem)
                                                     : (bus.ref_elem - bus.pixel_elem);
  assign sq       = (2*ELEMENT_WIDTH)'(s1_diff_q) * (2*ELEMENT_WIDTH)'(s1_diff_q);
  assign cnt_inc  = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    s1_diff_d   = s1_diff_q;
    s1_valid_d  = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ref_d       = ref_q;
    trunc_d     = trunc_q;
    out_valid_d = 1'b0;
    out_value_d = out_value_q;
    out_ref_d   = out_ref_q;
    out_trunc_d = out_trunc_q;
    div_start   = 1'b0;

    // S2 runs in every state; only ACCUM and DRAIN ever see s1_valid_q set.
    if (s1_valid_q) begin
      acc_d = acc_q + ACC_WIDTH'(sq);
    end

    case (state_q)
      Accum: begin
        if (hs) begin
          s1_valid_d = 1'b1;
          s1_diff_d  = abs_diff;
          cnt_d      = cnt_inc;
          if (cnt_q == '0) begin
            ref_d = bus.vector_ref;
          end
          if (bus.band_last || (cnt_inc == CntW'(HSI_BANDS))) begin
            state_d = Drain;
            ready_d = 1'b0;
            trunc_d = !bus.band_last;
          end
        end
      end
      Drain: begin
        // The last square lands this cycle, so the divider loads acc_d, not acc_q.
        div_start = 1'b1;
        state_d   = Divide;
      end
      Divide: begin
        if (div_done) begin
          state_d     = Output;
          out_valid_d = 1'b1;
          out_value_d = WORD_WIDTH'(sat_resize(64'(div_quo), WORD_WIDTH));
          out_ref_d   = ref_q;
          out_trunc_d = trunc_q;
        end
      end
      Output: begin
        state_d = Accum;
        ready_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        trunc_d = 1'b0;
      end
      default: begin
        state_d = Accum;
        ready_d = 1'b1;
      end
    endcase

    if (clear) begin
      state_d     = Accum;
      ready_d     = 1'b1;
      s1_diff_d   = '0;
      s1_valid_d  = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      ref_d       = '0;
      trunc_d     = 1'b0;
      out_valid_d = 1'b0;
      out_value_d = '0;
      out_ref_d   = '0;
      out_trunc_d = 1'b0;
      div_start   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= Accum;
      ready_q     <= 1'b1;
      s1_diff_q   <= '0;
      s1_valid_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ref_q       <= '0;
      trunc_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ref_q   <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      s1_diff_q   <= s1_diff_d;
      s1_valid_q  <= s1_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      trunc_q     <= trunc_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_ref_q   <= out_ref_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  hsi_mse_div #(
    .DividendWidth(ACC_WIDTH),
    .DivisorWidth (CntW)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .start_i   (div_start),
    .dividend_i(acc_d),
    .divisor_i (cnt_q),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

  // The divider is always either iterating or presenting its result while we wait on it.
  a_divide_tracks_div : assert property (
    @(posedge clk) disable iff (rst) (state_q == Divide) |-> (div_busy || div_done)
  );

  assign bus.band_ready        = ready_q;
  assign bus.mse_out_valid     = out_valid_q;
  assign bus.mse_out_value     = out_value_q;
  assign bus.mse_out_ref       = out_ref_q;
  assign bus.mse_out_truncated = out_trunc_q;

endmodule

// File: tb/tb_hsi_mse_acc.sv
// Directed self-checking bench for hsi_mse_acc with hand-computed expected MSE values.
module tb_hsi_mse_acc;

  localparam int Latency = 41;  // result pulse cycle minus last-handshake cycle

  logic clk = 1'b0;
  logic rst;
  logic clear;

  hsi_mse_acc_if bus ();

  hsi_mse_acc dut (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint value;
    int     vref;
    bit     trunc;
    int     cyc;
  } pulse_t;

  pulse_t pq[$];

  always @(negedge clk) begin
    if (bus.mse_out_valid === 1'b1) begin
      pq.push_back('{value: longint'(bus.mse_out_value), vref: int'(bus.mse_out_ref),
                     trunc: bus.mse_out_truncated, cyc: cyc});
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int pix_a[128];
  int ref_a[128];
  int first_hs;
  int last_hs;

  // Presents n bands; bands after the first carry a different vector_ref that must be ignored.
  task automatic send_vec(input int n, input bit use_last, input int vref, input bit keep_valid);
    for (int i = 0; i < n; i++) begin
      int g;
      @(negedge clk);
      bus.band_valid = 1'b1;
      bus.pixel_elem = 16'(pix_a[i]);
      bus.ref_elem   = 16'(ref_a[i]);
      bus.band_last  = use_last && (i == n - 1);
      bus.vector_ref = (i == 0) ? 8'(vref) : 8'(vref ^ 'h5a);
      g = 0;
      while (bus.band_ready !== 1'b1 && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) check_eq("ready_wait", longint'(bus.band_ready), 1);
      if (i == 0) first_hs = cyc;
      last_hs = cyc;
      @(posedge clk);
    end
    if (!keep_valid) begin
      @(negedge clk);
      bus.band_valid = 1'b0;
      bus.band_last  = 1'b0;
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int g;
    g = 0;
    while (pq.size() < n && g < budget) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    check_eq("pulse_count", pq.size(), n);
  endtask

  task automatic check_pulse(input string tag, input longint value, input int vref,
                             input bit trunc, input int hs_cyc);
    pulse_t p;
    if (pq.size() == 0) begin
      check_eq({tag, "_present"}, 0, 1);
      return;
    end
    p = pq.pop_front();
    check_eq({tag, "_value"}, p.value, value);
    check_eq({tag, "_ref"}, p.vref, vref);
    check_eq({tag, "_trunc"}, p.trunc, trunc);
    if (hs_cyc >= 0) check_eq({tag, "_latency"}, p.cyc - hs_cyc, Latency);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v1_last;
    int p1_cyc;
    rst            = 1'b1;
    clear          = 1'b0;
    bus.band_valid = 1'b0;
    bus.pixel_elem = '0;
    bus.ref_elem   = '0;
    bus.band_last  = 1'b0;
    bus.vector_ref = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_ready", bus.band_ready, 1);
    check_eq("rst_valid", bus.mse_out_valid, 0);
    check_eq("rst_value", bus.mse_out_value, 0);
    check_eq("rst_ref", bus.mse_out_ref, 0);
    check_eq("rst_trunc", bus.mse_out_truncated, 0);

    // Four bands: squares 4+0+9+0 = 13, 13/4 = 3
    pix_a[0:3] = '{10, 20, 30, 40};
    ref_a[0:3] = '{12, 20, 27, 40};
    send_vec(4, 1'b1, 5, 1'b0);
    check_eq("four_ready_drop", bus.band_ready, 0);
    wait_pulses(1, 100);
    check_pulse("four", 3, 5, 1'b0, last_hs);
    @(negedge clk);
    check_eq("four_hold_value", bus.mse_out_value, 3);
    check_eq("four_hold_valid", bus.mse_out_valid, 0);
    check_eq("four_ready_back", bus.band_ready, 1);

    // Single band worst case: 65535^2 / 1
    pix_a[0] = 0;
    ref_a[0] = 65535;
    send_vec(1, 1'b1, 9, 1'b0);
    wait_pulses(1, 100);
    check_pulse("single", 64'd4294836225, 9, 1'b0, last_hs);

    // Implicit last after 128 bands, no band_last
    for (int i = 0; i < 128; i++) begin
      pix_a[i] = 65535;
      ref_a[i] = 0;
    end
    send_vec(128, 1'b0, 200, 1'b0);
    check_eq("trunc_ready_drop", bus.band_ready, 0);
    wait_pulses(1, 100);
    check_pulse("trunc", 64'd4294836225, 200, 1'b1, last_hs);

    // Back-to-back with band_valid held high: sums 9 and 30
    pix_a[0:2] = '{5, 7, 9};
    ref_a[0:2] = '{4, 9, 7};
    send_vec(3, 1'b1, 7, 1'b1);
    v1_last = last_hs;
    pix_a[0:2] = '{100, 3, 50};
    ref_a[0:2] = '{101, 5, 45};
    send_vec(3, 1'b1, 8, 1'b0);
    wait_pulses(2, 100);
    p1_cyc = (pq.size() > 0) ? pq[0].cyc : -1000;
    check_eq("b2b_second_start", first_hs - p1_cyc, 1);
    check_pulse("b2b_first", 3, 7, 1'b0, v1_last);
    check_pulse("b2b_second", 10, 8, 1'b0, last_hs);

    // Clear during DIVIDE: no pulse, ready the following cycle
    pix_a[0:1] = '{20, 30};
    ref_a[0:1] = '{25, 35};
    send_vec(2, 1'b1, 11, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("clr_busy", bus.band_ready, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("clr_ready", bus.band_ready, 1);
    check_eq("clr_value", bus.mse_out_value, 0);
    repeat (60) @(posedge clk);
    check_eq("clr_no_pulse", pq.size(), 0);
    pix_a[0:1] = '{10, 10};
    ref_a[0:1] = '{12, 8};
    send_vec(2, 1'b1, 12, 1'b0);
    wait_pulses(1, 100);
    check_pulse("after_clr", 4, 12, 1'b0, last_hs);

    // Async reset after 2 of 4 bands, then a fresh vector
    pix_a[0:1] = '{200, 0};
    ref_a[0:1] = '{0, 150};
    send_vec(2, 1'b0, 21, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_value", bus.mse_out_value, 0);
    check_eq("arst_ref", bus.mse_out_ref, 0);
    check_eq("arst_ready", bus.band_ready, 1);
    check_eq("arst_valid", bus.mse_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    // squares 9+16+0+1 = 26, 26/4 = 6
    pix_a[0:3] = '{3, 4, 10, 1};
    ref_a[0:3] = '{0, 0, 10, 0};
    send_vec(4, 1'b1, 3, 1'b0);
    wait_pulses(1, 100);
    check_pulse("after_rst", 6, 3, 1'b0, last_hs);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hsi_mse_acc.md
# hsi_mse_acc

Computes the mean squared error between one hyperspectral pixel and one library reference vector, streamed one spectral band per cycle. Sits directly upstream of the MSE min/max comparator. It produces the `mse_out_valid` / `mse_out_value` / `mse_out_ref` triple that the comparator consumes as `mse_in_valid` / `mse_in_value` / `mse_in_ref`. Accumulation is pipelined and the final mean comes from a multi-cycle divider.

## Interface
- `WORD_WIDTH`, 32: output MSE width.
- `ELEMENT_WIDTH`, 16: unsigned band sample width.
- `HSI_BANDS`, 128: maximum bands per vector.
- `HSI_BANDS_ADDR`, `$clog2(HSI_BANDS)`: band index width.
- `HSI_LIBRARY_SIZE`, 256: library entries.
- `HSI_LIBRARY_SIZE_ADDR`, `$clog2(HSI_LIBRARY_SIZE)`: reference index width.
- `ACC_WIDTH`, `2*ELEMENT_WIDTH+HSI_BANDS_ADDR`: accumulator and dividend width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous abort to idle state.
- `band_valid` in 1: band element present.
- `band_ready` out 1: element accepted when `band_valid && band_ready`.
- `pixel_elem` in `ELEMENT_WIDTH`: pixel sample.
- `ref_elem` in `ELEMENT_WIDTH`: library sample.
- `band_last` in 1: final band of the vector.
- `vector_ref` in `HSI_LIBRARY_SIZE_ADDR`: library index; sampled on the first accepted band of a vector.
- `mse_out_valid` out 1: one-cycle result pulse.
- `mse_out_value` out `WORD_WIDTH`: floor(sum of squared differences / band count).
- `mse_out_ref` out `HSI_LIBRARY_SIZE_ADDR`: index of the vector that produced the result.
- `mse_out_truncated` out 1: the vector hit `HSI_BANDS` without `band_last`.

## Operation
- Reset and `clear` both force the same state:
  - state ACCUM;
  - accumulator, band counter and pipeline valids cleared;
  - `band_ready`=1;
  - all other outputs 0.
- `clear` has priority over every other input. It discards any in-flight vector and produces no output pulse.
- States:
  - **ACCUM**: `band_ready`=1.
    - Stage S1 registers `|pixel_elem - ref_elem|` (ELEMENT_WIDTH bits, unsigned), plus last and valid.
    - Stage S2 adds the square (2*ELEMENT_WIDTH bits) into the accumulator.
    - The band counter (HSI_BANDS_ADDR+1 bits) increments on each handshake.
  - **ACCUM → DRAIN**: on a handshake with `band_last`, or on the handshake that makes the count equal `HSI_BANDS`. The second case is an implicit last and sets the truncated flag.
  - **DRAIN**: `band_ready`=0. Waits one cycle for S2 to fold in the last square, then moves to DIVIDE.
  - **DIVIDE**: restoring division of the accumulator by the band count, one quotient bit per cycle, ACC_WIDTH cycles. Then moves to OUTPUT.
  - **OUTPUT**: `mse_out_valid`=1 for exactly one cycle.
    - The quotient saturates to all-ones if it exceeds WORD_WIDTH bits. With default parameters it never does.
    - Accumulator and counter are cleared.
    - Next state is ACCUM.
- Outputs `mse_out_value`, `mse_out_ref` and `mse_out_truncated` hold their values after the pulse until the next OUTPUT.
- The count is never 0 when dividing. A one-band vector divides by 1.
- `vector_ref` changes mid-vector are ignored.

## Timing
- Cycle N: handshake with last (explicit or implicit).
- N+1: DRAIN.
- N+2 … N+1+ACC_WIDTH: DIVIDE.
- N+2+ACC_WIDTH: `mse_out_valid`=1. With defaults that is N+41.
- `band_ready` is 0 from N+1 through N+2+ACC_WIDTH and returns to 1 at N+3+ACC_WIDTH.
- Throughput: one vector per (bands + ACC_WIDTH + 2) cycles.
- `band_valid` may stay high across vectors. No element is lost or duplicated.

## Structure
- Package `hsi_mse_acc_pkg` holds:
  - the state enum `{ACCUM, DRAIN, DIVIDE, OUTPUT}`;
  - the ACC_WIDTH derivation function;
  - the saturating resize function.
- Sub-module `hsi_mse_div`: a sequential restoring divider.
  - Ports: `clk`, `rst`, `clear`, `start`, dividend, divisor, `busy`, `done`, quotient.
  - Fixed latency of ACC_WIDTH cycles after `start`.
- Top level holds the FSM, the S1/S2 pipeline, the counter and the output registers.

## Test plan
- **Four-band vector:**
  - Stimulus: pixel {10,20,30,40}, ref {12,20,27,40}, `vector_ref`=5.
  - Response: `mse_out_value`=3 (13/4), `mse_out_ref`=5, `mse_out_truncated`=0, pulse exactly 41 cycles after the last handshake.
- **Single-band worst case:**
  - Stimulus: one band, pixel 0, ref 65535, with last.
  - Response: value 4294836225, count 1.
- **Implicit last:**
  - Stimulus: 128 bands, all |diff|=65535, `band_last` never asserted.
  - Response: value 4294836225, `mse_out_truncated`=1, `band_ready` drops after the 128th element.
- **Back-to-back vectors:**
  - Stimulus: two 3-band vectors with `band_valid` held high; refs 7 then 8; squared-diff sums 9 and 30.
  - Response: two pulses, values 3 then 10, refs 7 then 8, no element of the second vector consumed before ready returns.
- **`clear` during DIVIDE:**
  - Response: no pulse, `band_ready`=1 the next cycle.
  - A following 2-band vector (sum 8) yields 4.
- **`rst` mid-accumulation:**
  - Assert `rst` asynchronously after 2 of 4 bands.
  - Response: all outputs 0 immediately. A fresh vector afterwards computes correctly with no residue.
